// File: rtl/ysyx_22050710_axi4_arbiter_2x1.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050710_axi4_arbiter_2x1
// Purpose  : Two-master (IFU=M0, LSU=M1) to one-slave AXI4 arbiter with
//            independent round-robin read and write paths.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050710_axi4_arbiter_2x1 #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  i_aclk,
    input  logic                  i_rst,
    // master 0 read
    input  logic [3:0]            i_m0_arid,
    input  logic [ADDR_WIDTH-1:0] i_m0_araddr,
    input  logic [7:0]            i_m0_arlen,
    input  logic [2:0]            i_m0_arsize,
    input  logic [1:0]            i_m0_arburst,
    input  logic                  i_m0_arvalid,
    output logic                  o_m0_arready,
    output logic [3:0]            o_m0_rid,
    output logic [DATA_WIDTH-1:0] o_m0_rdata,
    output logic [1:0]            o_m0_rresp,
    output logic                  o_m0_rlast,
    output logic                  o_m0_rvalid,
    input  logic                  i_m0_rready,
    // master 0 write
    input  logic [3:0]            i_m0_awid,
    input  logic [ADDR_WIDTH-1:0] i_m0_awaddr,
    input  logic [7:0]            i_m0_awlen,
    input  logic [2:0]            i_m0_awsize,
    input  logic [1:0]            i_m0_awburst,
    input  logic                  i_m0_awvalid,
    output logic                  o_m0_awready,
    input  logic [DATA_WIDTH-1:0] i_m0_wdata,
    input  logic [STRB_WIDTH-1:0] i_m0_wstrb,
    input  logic                  i_m0_wlast,
    input  logic                  i_m0_wvalid,
    output logic                  o_m0_wready,
    output logic [3:0]            o_m0_bid,
    output logic [1:0]            o_m0_bresp,
    output logic                  o_m0_bvalid,
    input  logic                  i_m0_bready,
    // master 1 read
    input  logic [3:0]            i_m1_arid,
    input  logic [ADDR_WIDTH-1:0] i_m1_araddr,
    input  logic [7:0]            i_m1_arlen,
    input  logic [2:0]            i_m1_arsize,
    input  logic [1:0]            i_m1_arburst,
    input  logic                  i_m1_arvalid,
    output logic                  o_m1_arready,
    output logic [3:0]            o_m1_rid,
    output logic [DATA_WIDTH-1:0] o_m1_rdata,
    output logic [1:0]            o_m1_rresp,
    output logic                  o_m1_rlast,
    output logic                  o_m1_rvalid,
    input  logic                  i_m1_rready,
    // master 1 write
    input  logic [3:0]            i_m1_awid,
    input  logic [ADDR_WIDTH-1:0] i_m1_awaddr,
    input  logic [7:0]            i_m1_awlen,
    input  logic [2:0]            i_m1_awsize,
    input  logic [1:0]            i_m1_awburst,
    input  logic                  i_m1_awvalid,
    output logic                  o_m1_awready,
    input  logic [DATA_WIDTH-1:0] i_m1_wdata,
    input  logic [STRB_WIDTH-1:0] i_m1_wstrb,
    input  logic                  i_m1_wlast,
    input  logic                  i_m1_wvalid,
    output logic                  o_m1_wready,
    output logic [3:0]            o_m1_bid,
    output logic [1:0]            o_m1_bresp,
    output logic                  o_m1_bvalid,
    input  logic                  i_m1_bready,
    // slave read
    output logic [3:0]            o_s_arid,
    output logic [ADDR_WIDTH-1:0] o_s_araddr,
    output logic [7:0]            o_s_arlen,
    output logic [2:0]            o_s_arsize,
    output logic [1:0]            o_s_arburst,
    output logic [1:0]            o_s_arlock,
    output logic [3:0]            o_s_arcache,
    output logic [2:0]            o_s_arprot,
    output logic                  o_s_arvalid,
    input  logic                  i_s_arready,
    input  logic [3:0]            i_s_rid,
    input  logic [DATA_WIDTH-1:0] i_s_rdata,
    input  logic [1:0]            i_s_rresp,
    input  logic                  i_s_rlast,
    input  logic                  i_s_rvalid,
    output logic                  o_s_rready,
    // slave write
    output logic [3:0]            o_s_awid,
    output logic [ADDR_WIDTH-1:0] o_s_awaddr,
    output logic [7:0]            o_s_awlen,
    output logic [2:0]            o_s_awsize,
    output logic [1:0]            o_s_awburst,
    output logic [1:0]            o_s_awlock,
    output logic [3:0]            o_s_awcache,
    output logic [2:0]            o_s_awprot,
    output logic                  o_s_awvalid,
    input  logic                  i_s_awready,
    output logic [DATA_WIDTH-1:0] o_s_wdata,
    output logic [STRB_WIDTH-1:0] o_s_wstrb,
    output logic                  o_s_wlast,
    output logic                  o_s_wvalid,
    input  logic                  i_s_wready,
    input  logic [3:0]            i_s_bid,
    input  logic [1:0]            i_s_bresp,
    input  logic                  i_s_bvalid,
    output logic                  o_s_bready
);

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_ADDR = 2'd1,
        WR_DATA = 2'd2,
        WR_RESP = 2'd3
    } wr_state_t;

    rd_state_t r_rd_state;
    logic      r_rd_gnt;
    logic      r_rd_last;
    wr_state_t r_wr_state;
    logic      r_wr_gnt;
    logic      r_wr_last;

    logic w_rd_addr, w_rd_data;
    logic w_wr_addr, w_wr_data, w_wr_resp;
    logic w_s_ar_fire, w_s_r_fire, w_s_aw_fire, w_s_w_fire, w_s_b_fire;

    assign w_rd_addr = (r_rd_state == RD_ADDR);
    assign w_rd_data = (r_rd_state == RD_DATA);
    assign w_wr_addr = (r_wr_state == WR_ADDR);
    assign w_wr_data = (r_wr_state == WR_DATA);
    assign w_wr_resp = (r_wr_state == WR_RESP);

    // ------------------------------------------------------------------
    // Read path: a tie goes to the master that was not served last
    // ------------------------------------------------------------------
    always_ff @(posedge i_aclk) begin
        if (i_rst) begin
            r_rd_state <= RD_IDLE;
            r_rd_gnt   <= 1'b0;
            r_rd_last  <= 1'b1;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    if (i_m0_arvalid || i_m1_arvalid) begin
                        r_rd_gnt   <= (i_m0_arvalid && i_m1_arvalid) ? ~r_rd_last : i_m1_arvalid;
                        r_rd_state <= RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (w_s_ar_fire) r_rd_state <= RD_DATA;
                end
                RD_DATA: begin
                    if (w_s_r_fire && i_s_rlast) begin
                        r_rd_last  <= r_rd_gnt;
                        r_rd_state <= RD_IDLE;
                    end
                end
                default: r_rd_state <= RD_IDLE;
            endcase
        end
    end

    assign o_s_arid    = r_rd_gnt ? i_m1_arid    : i_m0_arid;
    assign o_s_araddr  = r_rd_gnt ? i_m1_araddr  : i_m0_araddr;
    assign o_s_arlen   = r_rd_gnt ? i_m1_arlen   : i_m0_arlen;
    assign o_s_arsize  = r_rd_gnt ? i_m1_arsize  : i_m0_arsize;
    assign o_s_arburst = r_rd_gnt ? i_m1_arburst : i_m0_arburst;
    assign o_s_arlock  = 2'b00;
    assign o_s_arcache = 4'b0000;
    assign o_s_arprot  = 3'b000;
    assign o_s_arvalid = w_rd_addr & (r_rd_gnt ? i_m1_arvalid : i_m0_arvalid);
    assign o_m0_arready = w_rd_addr & ~r_rd_gnt & i_s_arready;
    assign o_m1_arready = w_rd_addr &  r_rd_gnt & i_s_arready;
    assign w_s_ar_fire  = o_s_arvalid & i_s_arready;

    assign o_m0_rid    = i_s_rid;
    assign o_m0_rdata  = i_s_rdata;
    assign o_m0_rresp  = i_s_rresp;
    assign o_m0_rlast  = w_rd_data & ~r_rd_gnt & i_s_rlast;
    assign o_m0_rvalid = w_rd_data & ~r_rd_gnt & i_s_rvalid;
    assign o_m1_rid    = i_s_rid;
    assign o_m1_rdata  = i_s_rdata;
    assign o_m1_rresp  = i_s_rresp;
    assign o_m1_rlast  = w_rd_data &  r_rd_gnt & i_s_rlast;
    assign o_m1_rvalid = w_rd_data &  r_rd_gnt & i_s_rvalid;
    assign o_s_rready  = w_rd_data & (r_rd_gnt ? i_m1_rready : i_m0_rready);
    assign w_s_r_fire  = i_s_rvalid & o_s_rready;

    // ------------------------------------------------------------------
    // Write path: grant is held from AW through the B handshake
    // ------------------------------------------------------------------
    always_ff @(posedge i_aclk) begin
        if (i_rst) begin
            r_wr_state <= WR_IDLE;
            r_wr_gnt   <= 1'b0;
            r_wr_last  <= 1'b1;
        end else begin
            case (r_wr_state)
                WR_IDLE: begin
                    if (i_m0_awvalid || i_m1_awvalid) begin
                        r_wr_gnt   <= (i_m0_awvalid && i_m1_awvalid) ? ~r_wr_last : i_m1_awvalid;
                        r_wr_state <= WR_ADDR;
                    end
                end
                WR_ADDR: begin
                    if (w_s_aw_fire) r_wr_state <= WR_DATA;
                end
                WR_DATA: begin
                    if (w_s_w_fire && o_s_wlast) r_wr_state <= WR_RESP;
                end
                WR_RESP: begin
                    if (w_s_b_fire) begin
                        r_wr_last  <= r_wr_gnt;
                        r_wr_state <= WR_IDLE;
                    end
                end
                default: r_wr_state <= WR_IDLE;
            endcase
        end
    end

    assign o_s_awid    = r_wr_gnt ? i_m1_awid    : i_m0_awid;
    assign o_s_awaddr  = r_wr_gnt ? i_m1_awaddr  : i_m0_awaddr;
    assign o_s_awlen   = r_wr_gnt ? i_m1_awlen   : i_m0_awlen;
    assign o_s_awsize  = r_wr_gnt ? i_m1_awsize  : i_m0_awsize;
    assign o_s_awburst = r_wr_gnt ? i_m1_awburst : i_m0_awburst;
    assign o_s_awlock  = 2'b00;
    assign o_s_awcache = 4'b0000;
    assign o_s_awprot  = 3'b000;
    assign o_s_awvalid = w_wr_addr & (r_wr_gnt ? i_m1_awvalid : i_m0_awvalid);
    assign o_m0_awready = w_wr_addr & ~r_wr_gnt & i_s_awready;
    assign o_m1_awready = w_wr_addr &  r_wr_gnt & i_s_awready;
    assign w_s_aw_fire  = o_s_awvalid & i_s_awready;

    assign o_s_wdata   = r_wr_gnt ? i_m1_wdata : i_m0_wdata;
    assign o_s_wstrb   = r_wr_gnt ? i_m1_wstrb : i_m0_wstrb;
    assign o_s_wlast   = w_wr_data & (r_wr_gnt ? i_m1_wlast  : i_m0_wlast);
    assign o_s_wvalid  = w_wr_data & (r_wr_gnt ? i_m1_wvalid : i_m0_wvalid);
    assign o_m0_wready = w_wr_data & ~r_wr_gnt & i_s_wready;
    assign o_m1_wready = w_wr_data &  r_wr_gnt & i_s_wready;
    assign w_s_w_fire  = o_s_wvalid & i_s_wready;

    assign o_m0_bid    = i_s_bid;
    assign o_m0_bresp  = i_s_bresp;
    assign o_m0_bvalid = w_wr_resp & ~r_wr_gnt & i_s_bvalid;
    assign o_m1_bid    = i_s_bid;
    assign o_m1_bresp  = i_s_bresp;
    assign o_m1_bvalid = w_wr_resp &  r_wr_gnt & i_s_bvalid;
    assign o_s_bready  = w_wr_resp & (r_wr_gnt ? i_m1_bready : i_m0_bready);
    assign w_s_b_fire  = i_s_bvalid & o_s_bready;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050710_axi4_arbiter_2x1.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22050710_axi4_arbiter_2x1
// Purpose  : Randomized two-master / one-slave traffic against a transaction
//            level round-robin model, plus directed latency and reset cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050710_axi4_arbiter_2x1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // master side, indexed by master number
    logic [3:0]  m_arid[2];   logic [31:0] m_araddr[2]; logic [7:0] m_arlen[2];
    logic [2:0]  m_arsize[2]; logic [1:0]  m_arburst[2]; logic m_arvalid[2]; logic m_arready[2];
    logic [3:0]  m_rid[2];    logic [63:0] m_rdata[2];  logic [1:0] m_rresp[2];
    logic        m_rlast[2];  logic m_rvalid[2]; logic m_rready[2];
    logic [3:0]  m_awid[2];   logic [31:0] m_awaddr[2]; logic [7:0] m_awlen[2];
    logic [2:0]  m_awsize[2]; logic [1:0]  m_awburst[2]; logic m_awvalid[2]; logic m_awready[2];
    logic [63:0] m_wdata[2];  logic [7:0]  m_wstrb[2];  logic m_wlast[2]; logic m_wvalid[2]; logic m_wready[2];
    logic [3:0]  m_bid[2];    logic [1:0]  m_bresp[2];  logic m_bvalid[2]; logic m_bready[2];

    // slave side
    logic [3:0]  s_arid;  logic [31:0] s_araddr; logic [7:0] s_arlen; logic [2:0] s_arsize; logic [1:0] s_arburst;
    logic [1:0]  s_arlock; logic [3:0] s_arcache; logic [2:0] s_arprot; logic s_arvalid; logic s_arready;
    logic [3:0]  s_rid;   logic [63:0] s_rdata; logic [1:0] s_rresp; logic s_rlast, s_rvalid, s_rready;
    logic [3:0]  s_awid;  logic [31:0] s_awaddr; logic [7:0] s_awlen; logic [2:0] s_awsize; logic [1:0] s_awburst;
    logic [1:0]  s_awlock; logic [3:0] s_awcache; logic [2:0] s_awprot; logic s_awvalid; logic s_awready;
    logic [63:0] s_wdata; logic [7:0] s_wstrb; logic s_wlast, s_wvalid, s_wready;
    logic [3:0]  s_bid;   logic [1:0] s_bresp; logic s_bvalid, s_bready;

    ysyx_22050710_axi4_arbiter_2x1 dut (
        .i_aclk(clk), .i_rst(rst),
        .i_m0_arid(m_arid[0]), .i_m0_araddr(m_araddr[0]), .i_m0_arlen(m_arlen[0]), .i_m0_arsize(m_arsize[0]),
        .i_m0_arburst(m_arburst[0]), .i_m0_arvalid(m_arvalid[0]), .o_m0_arready(m_arready[0]),
        .o_m0_rid(m_rid[0]), .o_m0_rdata(m_rdata[0]), .o_m0_rresp(m_rresp[0]), .o_m0_rlast(m_rlast[0]),
        .o_m0_rvalid(m_rvalid[0]), .i_m0_rready(m_rready[0]),
        .i_m0_awid(m_awid[0]), .i_m0_awaddr(m_awaddr[0]), .i_m0_awlen(m_awlen[0]), .i_m0_awsize(m_awsize[0]),
        .i_m0_awburst(m_awburst[0]), .i_m0_awvalid(m_awvalid[0]), .o_m0_awready(m_awready[0]),
        .i_m0_wdata(m_wdata[0]), .i_m0_wstrb(m_wstrb[0]), .i_m0_wlast(m_wlast[0]), .i_m0_wvalid(m_wvalid[0]),
        .o_m0_wready(m_wready[0]), .o_m0_bid(m_bid[0]), .o_m0_bresp(m_bresp[0]), .o_m0_bvalid(m_bvalid[0]),
        .i_m0_bready(m_bready[0]),
        .i_m1_arid(m_arid[1]), .i_m1_araddr(m_araddr[1]), .i_m1_arlen(m_arlen[1]), .i_m1_arsize(m_arsize[1]),
        .i_m1_arburst(m_arburst[1]), .i_m1_arvalid(m_arvalid[1]), .o_m1_arready(m_arready[1]),
        .o_m1_rid(m_rid[1]), .o_m1_rdata(m_rdata[1]), .o_m1_rresp(m_rresp[1]), .o_m1_rlast(m_rlast[1]),
        .o_m1_rvalid(m_rvalid[1]), .i_m1_rready(m_rready[1]),
        .i_m1_awid(m_awid[1]), .i_m1_awaddr(m_awaddr[1]), .i_m1_awlen(m_awlen[1]), .i_m1_awsize(m_awsize[1]),
        .i_m1_awburst(m_awburst[1]), .i_m1_awvalid(m_awvalid[1]), .o_m1_awready(m_awready[1]),
        .i_m1_wdata(m_wdata[1]), .i_m1_wstrb(m_wstrb[1]), .i_m1_wlast(m_wlast[1]), .i_m1_wvalid(m_wvalid[1]),
        .o_m1_wready(m_wready[1]), .o_m1_bid(m_bid[1]), .o_m1_bresp(m_bresp[1]), .o_m1_bvalid(m_bvalid[1]),
        .i_m1_bready(m_bready[1]),
        .o_s_arid(s_arid), .o_s_araddr(s_araddr), .o_s_arlen(s_arlen), .o_s_arsize(s_arsize),
        .o_s_arburst(s_arburst), .o_s_arlock(s_arlock), .o_s_arcache(s_arcache), .o_s_arprot(s_arprot),
        .o_s_arvalid(s_arvalid), .i_s_arready(s_arready),
        .i_s_rid(s_rid), .i_s_rdata(s_rdata), .i_s_rresp(s_rresp), .i_s_rlast(s_rlast),
        .i_s_rvalid(s_rvalid), .o_s_rready(s_rready),
        .o_s_awid(s_awid), .o_s_awaddr(s_awaddr), .o_s_awlen(s_awlen), .o_s_awsize(s_awsize),
        .o_s_awburst(s_awburst), .o_s_awlock(s_awlock), .o_s_awcache(s_awcache), .o_s_awprot(s_awprot),
        .o_s_awvalid(s_awvalid), .i_s_awready(s_awready),
        .o_s_wdata(s_wdata), .o_s_wstrb(s_wstrb), .o_s_wlast(s_wlast), .o_s_wvalid(s_wvalid),
        .i_s_wready(s_wready),
        .i_s_bid(s_bid), .i_s_bresp(s_bresp), .i_s_bvalid(s_bvalid), .o_s_bready(s_bready)
    );

    localparam int ROUNDS = 40;

    int n_checks = 0;
    int n_pass   = 0;
    bit rd_busy[2];
    bit wr_busy[2];
    bit rd_done = 1'b0;
    bit wr_done = 1'b0;
    logic [3:0] rd_order[$];
    logic [3:0] wr_order[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // payload patterns both ends derive independently
    function automatic logic [63:0] rfn(input logic [3:0] id, input logic [31:0] a, input int b);
        return {a ^ 32'h5A5A_0000, 20'h0, id, 8'(b)};
    endfunction
    function automatic logic [63:0] wfn(input logic [3:0] id, input logic [31:0] a, input int b);
        return {~a, 8'(b), 20'hC0FFE, id};
    endfunction
    function automatic logic [7:0] sfn(input logic [3:0] id, input int b);
        return 8'(int'(id) * 37 + b);
    endfunction

    function automatic logic [17:0] all_handshakes();
        return {m_arready[0], m_arready[1], m_rvalid[0], m_rvalid[1], m_rlast[0], m_rlast[1],
                m_awready[0], m_awready[1], m_wready[0], m_wready[1], m_bvalid[0], m_bvalid[1],
                s_arvalid, s_rready, s_awvalid, s_wvalid, s_wlast, s_bready};
    endfunction

    task automatic mread(input int m, input logic [3:0] id, input logic [31:0] a, input int len);
        int b;
        m_arid[m] = id; m_araddr[m] = a; m_arlen[m] = 8'(len);
        m_arsize[m] = {1'b0, id[1:0]}; m_arburst[m] = 2'b01; m_arvalid[m] = 1'b1;
        @(negedge clk);
        while (!m_arready[m]) @(negedge clk);
        @(posedge clk); #1;
        m_arvalid[m] = 1'b0; rd_busy[m] = 1'b1; b = 0;
        while (b <= len) begin
            m_rready[m] = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (m_rvalid[m] && m_rready[m]) begin
                check_eq("m_rdata", m_rdata[m], rfn(id, a, b));
                check_eq("m_rid",   m_rid[m], id);
                check_eq("m_rresp", m_rresp[m], id[1:0]);
                check_eq("m_rlast", m_rlast[m], (b == len));
                b++;
            end
            @(posedge clk); #1;
        end
        m_rready[m] = 1'b0; rd_busy[m] = 1'b0;
    endtask

    task automatic mwrite(input int m, input logic [3:0] id, input logic [31:0] a, input int len);
        int b;
        bit got;
        m_awid[m] = id; m_awaddr[m] = a; m_awlen[m] = 8'(len);
        m_awsize[m] = 3'd3; m_awburst[m] = 2'b01; m_awvalid[m] = 1'b1;
        @(negedge clk);
        while (!m_awready[m]) @(negedge clk);
        @(posedge clk); #1;
        m_awvalid[m] = 1'b0; wr_busy[m] = 1'b1; b = 0;
        while (b <= len) begin
            m_wvalid[m] = ($urandom_range(0, 3) != 0);
            m_wdata[m] = wfn(id, a, b); m_wstrb[m] = sfn(id, b); m_wlast[m] = (b == len);
            @(negedge clk);
            if (m_wvalid[m] && m_wready[m]) b++;
            @(posedge clk); #1;
        end
        m_wvalid[m] = 1'b0; m_wlast[m] = 1'b0; got = 1'b0;
        while (!got) begin
            m_bready[m] = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (m_bvalid[m] && m_bready[m]) begin
                check_eq("m_bid",   m_bid[m], id);
                check_eq("m_bresp", m_bresp[m], a[4:3]);
                got = 1'b1;
            end
            @(posedge clk); #1;
        end
        m_bready[m] = 1'b0; wr_busy[m] = 1'b0;
    endtask

    task automatic rd_slave();
        logic [3:0] id; logic [31:0] a; int len; int b;
        while (!rd_done) begin
            @(posedge clk); #1;
            s_arready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (s_arvalid && s_arready) begin
                id = s_arid; a = s_araddr; len = int'(s_arlen);
                rd_order.push_back(id);
                check_eq("s_arsize", s_arsize, {1'b0, id[1:0]});
                @(posedge clk); #1;
                s_arready = 1'b0; b = 0;
                while (b <= len) begin
                    s_rvalid = ($urandom_range(0, 2) != 0);
                    s_rid = id; s_rdata = rfn(id, a, b); s_rresp = id[1:0]; s_rlast = (b == len);
                    @(negedge clk);
                    if (s_rvalid && s_rready) b++;
                    @(posedge clk); #1;
                end
                s_rvalid = 1'b0; s_rlast = 1'b0;
            end
        end
        s_arready = 1'b0;
    endtask

    task automatic wr_slave();
        logic [3:0] id; logic [31:0] a; int len; int b; bit fired;
        while (!wr_done) begin
            @(posedge clk); #1;
            s_awready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (s_awvalid && s_awready) begin
                id = s_awid; a = s_awaddr; len = int'(s_awlen);
                wr_order.push_back(id);
                @(posedge clk); #1;
                s_awready = 1'b0; b = 0;
                while (b <= len) begin
                    s_wready = ($urandom_range(0, 2) != 0);
                    @(negedge clk);
                    if (s_wvalid && s_wready) begin
                        check_eq("s_wdata", s_wdata, wfn(id, a, b));
                        check_eq("s_wstrb", s_wstrb, sfn(id, b));
                        check_eq("s_wlast", s_wlast, (b == len));
                        b++;
                    end
                    @(posedge clk); #1;
                end
                s_wready = 1'b0; s_bid = id; s_bresp = a[4:3]; fired = 1'b0;
                while (!fired) begin
                    s_bvalid = ($urandom_range(0, 2) != 0);
                    @(negedge clk);
                    fired = s_bvalid && s_bready;
                    @(posedge clk); #1;
                end
                s_bvalid = 1'b0;
            end
        end
        s_awready = 1'b0;
    endtask

    // Each round both masters start in the same cycle; a tie is won by the
    // master that was not served last, and order is read back from the slave.
    task automatic run_rounds(input bit is_write);
        int req; int first; int second; int n;
        int rr;
        logic [3:0] ids[2]; logic [31:0] addrs[2]; int lens[2];
        logic [3:0] t;
        rr = 1;
        @(posedge clk); #1;
        for (int r = 0; r < ROUNDS; r++) begin
            req = int'($urandom_range(1, 3));
            for (int m = 0; m < 2; m++) begin
                ids[m]   = 4'(m * 8 + int'($urandom_range(0, 7)));
                addrs[m] = {$urandom()} & 32'hFFFF_FFF8;
                lens[m]  = int'($urandom_range(0, 3));
            end
            fork
                begin
                    if (req[0]) begin
                        if (is_write) mwrite(0, ids[0], addrs[0], lens[0]);
                        else          mread(0, ids[0], addrs[0], lens[0]);
                    end
                end
                begin
                    if (req[1]) begin
                        if (is_write) mwrite(1, ids[1], addrs[1], lens[1]);
                        else          mread(1, ids[1], addrs[1], lens[1]);
                    end
                end
            join
            if (req == 3) begin first = 1 - rr; second = rr; n = 2; end
            else begin first = req - 1; second = first; n = 1; end
            rr = second;
            if (is_write) begin
                check_eq("wr_count", wr_order.size(), n);
                if (wr_order.size() > 0) begin t = wr_order.pop_front(); check_eq("wr_first", t[3], first[0]); end
                if (n == 2 && wr_order.size() > 0) begin t = wr_order.pop_front(); check_eq("wr_second", t[3], second[0]); end
                wr_order.delete();
            end else begin
                check_eq("rd_count", rd_order.size(), n);
                if (rd_order.size() > 0) begin t = rd_order.pop_front(); check_eq("rd_first", t[3], first[0]); end
                if (n == 2 && rd_order.size() > 0) begin t = rd_order.pop_front(); check_eq("rd_second", t[3], second[0]); end
                rd_order.delete();
            end
        end
        if (is_write) wr_done = 1'b1;
        else          rd_done = 1'b1;
    endtask

    // ready/valid toward a master only while that master owns the path
    task automatic monitor();
        while (!(rd_done && wr_done)) begin
            @(negedge clk);
            for (int x = 0; x < 2; x++) begin
                if (m_arready[x]) check_eq("arready_owner", {m_arvalid[x], rd_busy[1-x]}, 2'b10);
                if (m_rvalid[x])  check_eq("rvalid_owner", rd_busy[x], 1'b1);
                if (m_awready[x]) check_eq("awready_owner", {m_awvalid[x], wr_busy[1-x]}, 2'b10);
                if (m_wready[x])  check_eq("wready_owner", wr_busy[x], 1'b1);
                if (m_bvalid[x])  check_eq("bvalid_owner", wr_busy[x], 1'b1);
            end
        end
    endtask

    task automatic slave_inputs_high(input logic v);
        s_arready = v; s_rvalid = v; s_rlast = v; s_awready = v; s_wready = v; s_bvalid = v;
        m_rready[0] = v; m_rready[1] = v; m_bready[0] = v; m_bready[1] = v;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int m = 0; m < 2; m++) begin
            m_arid[m] = '0; m_araddr[m] = '0; m_arlen[m] = '0; m_arsize[m] = '0; m_arburst[m] = '0;
            m_arvalid[m] = 1'b0; m_rready[m] = 1'b0;
            m_awid[m] = '0; m_awaddr[m] = '0; m_awlen[m] = '0; m_awsize[m] = '0; m_awburst[m] = '0;
            m_awvalid[m] = 1'b0; m_wdata[m] = '0; m_wstrb[m] = '0; m_wlast[m] = 1'b0; m_wvalid[m] = 1'b0;
            m_bready[m] = 1'b0; rd_busy[m] = 1'b0; wr_busy[m] = 1'b0;
        end
        s_arready = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
        s_awready = 1'b0; s_wready = 1'b0; s_bid = '0; s_bresp = '0; s_bvalid = 1'b0;

        // reset state, with every slave-side ready/valid pushing high
        slave_inputs_high(1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outputs", all_handshakes(), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_outputs", all_handshakes(), '0);
        check_eq("const_axcache", {s_arlock, s_arcache, s_arprot, s_awlock, s_awcache, s_awprot}, '0);
        @(posedge clk); #1;
        slave_inputs_high(1'b0);

        fork
            run_rounds(1'b0);
            run_rounds(1'b1);
            rd_slave();
            wr_slave();
            monitor();
        join

        // M0 alone, len 0: slave sees arvalid one cycle after the request
        @(posedge clk); #1;
        m_arid[0] = 4'h2; m_araddr[0] = 32'h8000_0000; m_arlen[0] = 8'd0; m_arvalid[0] = 1'b1;
        s_arready = 1'b1;
        @(negedge clk);
        check_eq("lat_idle_arvalid", s_arvalid, 1'b0);
        @(negedge clk);
        check_eq("lat_addr_arvalid", s_arvalid, 1'b1);
        check_eq("lat_addr_araddr", s_araddr, 32'h8000_0000);
        check_eq("lat_m0_arready", {m_arready[0], m_arready[1]}, 2'b10);
        @(posedge clk); #1;
        m_arvalid[0] = 1'b0; s_arready = 1'b0;
        s_rvalid = 1'b1; s_rlast = 1'b1; s_rid = 4'h2; s_rdata = 64'h0123_4567_89AB_CDEF; m_rready[0] = 1'b1;
        @(negedge clk);
        check_eq("single_beat", {m_rvalid[0], m_rlast[0], m_rvalid[1]}, 3'b110);
        check_eq("single_rdata", m_rdata[0], 64'h0123_4567_89AB_CDEF);
        @(posedge clk); #1;
        s_rvalid = 1'b0; s_rlast = 1'b0; m_rready[0] = 1'b0;

        // M1 len 3 read, reset pulsed while beat 2 is on the bus
        m_arid[1] = 4'h9; m_araddr[1] = 32'h8000_0040; m_arlen[1] = 8'd3; m_arvalid[1] = 1'b1;
        s_arready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("m1_arready", {m_arready[0], m_arready[1]}, 2'b01);
        @(posedge clk); #1;
        m_arvalid[1] = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1; s_rid = 4'h9; m_rready[1] = 1'b1;
        @(negedge clk);
        check_eq("m1_beat1", {m_rvalid[0], m_rvalid[1], m_rlast[1]}, 3'b010);
        @(posedge clk); #1;
        rst = 1'b1;
        slave_inputs_high(1'b1);
        m_arid[0] = 4'h3; m_araddr[0] = 32'h8000_0080; m_arlen[0] = 8'd0; m_arvalid[0] = 1'b1;
        m_arid[1] = 4'hA; m_araddr[1] = 32'h8000_00C0; m_arlen[1] = 8'd0; m_arvalid[1] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("midreset_outputs", all_handshakes(), '0);
        @(negedge clk);
        check_eq("post_reset_tie", {m_arready[0], m_arready[1]}, 2'b10);
        check_eq("post_reset_arid", s_arid, 4'h3);
        @(posedge clk); #1;
        m_arvalid[0] = 1'b0; m_arvalid[1] = 1'b0;
        slave_inputs_high(1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
